// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame geometry and
// the idle level of the serial line. Used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int   DEFAULT_WORD_SIZE    = 8;
   localparam int   DEFAULT_CLKS_PER_BIT = 16;
   localparam logic LINE_IDLE            = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input. Resets to
// the line idle level so a reset never looks like a start bit.
module uart_sync
   import uart_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the flop chain; oldest bit is the output.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= {STAGES{LINE_IDLE}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start / WORD_SIZE data (LSB first) / stop frames
// from an asynchronous line, holds each byte behind a level-valid/ack
// handshake and flags framing and overrun errors.
// Optional build macro UART_RX_PARITY_EN adds a parity bit between the data
// and stop bits, plus the Parity_odd input and Parity_error output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 Serial_in,
   input  logic                 Read_ack,
   output logic [WORD_SIZE-1:0] uart_rx_data_Bus,
   output logic                 Byte_ready,
   output logic                 Framing_error,
   output logic                 Overrun,
   output logic                 Rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   input  logic                 Parity_odd,
   output logic                 Parity_error
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(WORD_SIZE + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_SIZE - 1);

   logic                 sin;
   uart_state_t          state_q;
   logic [CNT_W-1:0]     clk_cnt_q;
   logic [CNT_W-1:0]     clk_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [WORD_SIZE-1:0] shreg_q;
   logic [WORD_SIZE-1:0] data_q;
   logic                 byte_ready_q;
   logic                 framing_error_q;
   logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bad_q;
   logic                 parity_error_q;
`endif

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (Serial_in),
      .sync_o  (sin)
   );

   // Free-running increment of the bit-timing counter.
   always_comb begin
      clk_cnt_d = clk_cnt_q + 1'b1;
   end

   // Receive FSM with registered byte, handshake and error outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         clk_cnt_q       <= '0;
         bit_cnt_q       <= '0;
         shreg_q         <= '0;
         data_q          <= '0;
         byte_ready_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_q    <= 1'b0;
         parity_error_q  <= 1'b0;
`endif
      end else begin
         // Error flags are single-cycle pulses by default.
         framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error_q  <= 1'b0;
`endif
         // Host acknowledge; a good-stop load later in this block overrides it.
         if (Read_ack && byte_ready_q) begin
            byte_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               clk_cnt_q <= '0;
               if (!sin) begin
                  state_q <= START;
               end
            end

            START: begin
               // Re-check at mid start bit so short glitches are ignored.
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= sin ? IDLE : DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_d;
               end
            end

            DATA: begin
               if (clk_cnt_q == FULL_LAST) begin
                  clk_cnt_q <= '0;
                  shreg_q   <= {sin, shreg_q[WORD_SIZE-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_d;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               // Data plus parity bit must have odd (1) or even (0) weight.
               if (clk_cnt_q == FULL_LAST) begin
                  clk_cnt_q    <= '0;
                  parity_bad_q <= ((^shreg_q) ^ sin) != Parity_odd;
                  state_q      <= STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_d;
               end
            end
`endif

            STOP: begin
               if (clk_cnt_q == FULL_LAST) begin
                  clk_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                  parity_error_q <= parity_bad_q;
`endif
                  if (sin) begin
                     data_q       <= shreg_q;
                     byte_ready_q <= 1'b1;
                     if (byte_ready_q && !Read_ack) begin
                        overrun_q <= 1'b1;
                     end
                     state_q <= IDLE;
                  end else begin
                     framing_error_q <= 1'b1;
                     state_q         <= BREAK;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_d;
               end
            end

            BREAK: begin
               // Hold off until the line recovers so a stuck-low line
               // cannot retrigger a frame.
               clk_cnt_q <= '0;
               if (sin) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign uart_rx_data_Bus = data_q;
   assign Byte_ready       = byte_ready_q;
   assign Framing_error    = framing_error_q;
   assign Overrun          = overrun_q;
   assign Rx_busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign Parity_error     = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes the expected end-of-frame
// state when each frame starts; a monitor pops and compares it every time
// Rx_busy falls. Covers UART_RX_PARITY_EN when that macro is defined.
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PX = 16;
`else
   localparam int PX = 0;
`endif

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       Serial_in = 1'b1;
   logic       Read_ack  = 1'b0;
   logic [7:0] bus;
   logic       Byte_ready;
   logic       Framing_error;
   logic       Overrun;
   logic       Rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       Parity_odd  = 1'b0;
   logic       Parity_error;
`endif
   logic       flip_parity = 1'b0;

   uart_rx #(
      .WORD_SIZE    (8),
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .Serial_in        (Serial_in),
      .Read_ack         (Read_ack),
      .uart_rx_data_Bus (bus),
      .Byte_ready       (Byte_ready),
      .Framing_error    (Framing_error),
      .Overrun          (Overrun),
      .Rx_busy          (Rx_busy)
`ifdef UART_RX_PARITY_EN
      ,
      .Parity_odd       (Parity_odd),
      .Parity_error     (Parity_error)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] data;
      logic       rdy;
      logic       ovr;
      int         start;
      int         lat_min;
      int         lat_max;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   fe_cnt = 0;
   int   pe_cnt = 0;
   bit   mon_en = 1'b0;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic check_range(input string name, input int v, input int lo, input int hi);
      n_vec++;
      if (v < lo || v > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, v, lo, hi);
      end else begin
         $display("ok   %s = %0d", name, v);
      end
   endtask

   // Monitor: count error pulses; on every busy->idle transition compare the
   // held outputs and the frame latency against the next scoreboard entry.
   initial begin : monitor
      logic prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (Framing_error === 1'b1) fe_cnt++;
`ifdef UART_RX_PARITY_EN
            if (Parity_error === 1'b1) pe_cnt++;
`endif
            if (prev_busy === 1'b1 && Rx_busy === 1'b0) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_frame_end: bus=%0h, required no frame", bus);
               end else begin
                  e = exp_q.pop_front();
                  check({e.tag, "_data"}, 32'(bus), 32'(e.data));
                  check({e.tag, "_ready"}, 32'(Byte_ready), 32'(e.rdy));
                  check({e.tag, "_overrun"}, 32'(Overrun), 32'(e.ovr));
                  check_range({e.tag, "_latency"}, cyc - e.start, e.lat_min, e.lat_max);
               end
            end
            prev_busy = Rx_busy;
         end
      end
   end

   task automatic push(input logic [7:0] d, input logic rdy, input logic ovr,
                       input int lo, input int hi, input string tag);
      exp_t e;
      e.data    = d;
      e.rdy     = rdy;
      e.ovr     = ovr;
      e.start   = cyc;
      e.lat_min = lo;
      e.lat_max = hi;
      e.tag     = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive_bit(input logic b, input int n);
      Serial_in = b;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ Parity_odd ^ flip_parity, CPB);
`endif
      drive_bit(stop_bit, CPB);
   endtask

   task automatic ack();
      Read_ack = 1'b1;
      @(negedge clock);
      Read_ack = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset_bus", 32'(bus), 32'h0);
      check("reset_ready", 32'(Byte_ready), 32'h0);
      check("reset_overrun", 32'(Overrun), 32'h0);
      check("reset_framing", 32'(Framing_error), 32'h0);
      check("reset_busy", 32'(Rx_busy), 32'h0);
      mon_en = 1'b1;
      repeat (4) @(negedge clock);

      // Single byte, latency 9.5*16+2 = 154 +/-1.
      push(8'h41, 1'b1, 1'b0, 153 + PX, 155 + PX, "b41");
      send_frame(8'h41, 1'b1);
      ack();
      check("b41_acked_ready", 32'(Byte_ready), 32'h0);

      // Back-to-back with an acknowledge between frames.
      push(8'h55, 1'b1, 1'b0, 153 + PX, 155 + PX, "b55");
      send_frame(8'h55, 1'b1);
      ack();
      push(8'hAA, 1'b1, 1'b0, 153 + PX, 155 + PX, "bAA");
      send_frame(8'hAA, 1'b1);
      ack();

      // Second byte arrives while the first is unacknowledged.
      push(8'h3C, 1'b1, 1'b0, 153 + PX, 155 + PX, "b3C");
      send_frame(8'h3C, 1'b1);
      push(8'hC3, 1'b1, 1'b1, 153 + PX, 155 + PX, "bC3_overrun");
      send_frame(8'hC3, 1'b1);
      ack();
      check("overrun_acked_ready", 32'(Byte_ready), 32'h0);
      check("overrun_acked_overrun", 32'(Overrun), 32'h0);

      // 5-cycle low glitch: abandoned at mid start bit (8+2+1 = 11 cycles).
      push(8'hC3, 1'b0, 1'b0, 9, 11, "glitch");
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 30);

      // Stop bit low, line held low 40 more cycles; idle 3 cycles after release.
      push(8'hC3, 1'b0, 1'b0, 202 + PX, 204 + PX, "break");
      send_frame(8'h7E, 1'b0);
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 30);
      check("framing_pulses", 32'(fe_cnt), 32'd1);

      push(8'h12, 1'b1, 1'b0, 153 + PX, 155 + PX, "b12");
      send_frame(8'h12, 1'b1);

      // Reset during data bit 3 of 0xF0 while 0x12 is still held.
      push(8'h00, 1'b0, 1'b0, 0, 100000, "reset_mid");
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(1'b0, CPB);
      drive_bit(1'b0, 6);
      reset     = 1'b1;
      Serial_in = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midreset_bus", 32'(bus), 32'h0);
      check("midreset_ready", 32'(Byte_ready), 32'h0);
      check("midreset_busy", 32'(Rx_busy), 32'h0);
      check("midreset_framing", 32'(Framing_error), 32'h0);
      repeat (20) @(negedge clock);

      push(8'h0F, 1'b1, 1'b0, 153 + PX, 155 + PX, "b0F");
      send_frame(8'h0F, 1'b1);
      ack();
      check("b0F_acked_ready", 32'(Byte_ready), 32'h0);

`ifdef UART_RX_PARITY_EN
      check("parity_clean_frames", 32'(pe_cnt), 32'd0);
      // 0x07 has three ones; even parity needs bit 1, so bit 0 is an error.
      flip_parity = 1'b1;
      push(8'h07, 1'b1, 1'b0, 153 + PX, 155 + PX, "b07_parity");
      send_frame(8'h07, 1'b1);
      flip_parity = 1'b0;
      check("parity_error_pulses", 32'(pe_cnt), 32'd1);
`endif

      repeat (20) @(negedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("framing_pulses_total", 32'(fe_cnt), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver and counterpart of uart_tx. Samples asynchronous serial input and recovers 8N1 frames: 1 start bit, WORD_SIZE data bits LSB first, 1 stop bit.
Presents each byte on a parallel bus with a level-valid/acknowledge handshake to the host side of the UART/CAN bridge, and flags framing and overrun errors.

Parameters:
WORD_SIZE, 8, number of data bits per frame
CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4
SYNC_STAGES, 2, number of input synchronizer flops (>= 2)

Ports:
clock  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
Serial_in  input  1  asynchronous serial line; idles high
Read_ack  input  1  host acknowledges the byte currently held; one-cycle pulse
uart_rx_data_Bus  output  WORD_SIZE  last received byte; held until the next good frame
Byte_ready  output  1  level; high while uart_rx_data_Bus holds an unacknowledged byte
Framing_error  output  1  one-cycle pulse when the stop bit is sampled low
Overrun  output  1  sticky; set when a good frame completes while Byte_ready=1; cleared by Read_ack
Rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous and active-high: state=IDLE; counters=0; synchronizer flops=1; uart_rx_data_Bus=0; Byte_ready=0; Framing_error=0; Overrun=0.
- Reset mid-frame abandons the partial byte with no error pulse.
- All decisions use the synchronized input sin, which lags Serial_in by SYNC_STAGES cycles.
- State IDLE: sin==0 -> START; clear clk_cnt.
- State START: clk_cnt counts to CLKS_PER_BIT/2-1, which is mid start bit.
  - sin==0 at that point -> DATA; clear clk_cnt and bit_cnt.
  - sin==1 at that point -> IDLE. Glitch rejected; no error.
- State DATA: sample sin at clk_cnt==CLKS_PER_BIT-1, then clear clk_cnt.
  - Shift right into the shift register: shreg <= {sin, shreg[WORD_SIZE-1:1]}.
  - Increment bit_cnt. After sample number WORD_SIZE -> STOP (or PARITY when the optional feature is on).
- State STOP: sample sin at clk_cnt==CLKS_PER_BIT-1.
  - sin==1: load uart_rx_data_Bus<=shreg and set Byte_ready on the same edge. If Byte_ready was already 1 and Read_ack is 0 that cycle, set Overrun (new data still overwrites). Go to IDLE.
  - sin==0: pulse Framing_error for 1 cycle; bus and Byte_ready unchanged; go to BREAK.
- State BREAK: wait for sin==1, then IDLE. This prevents a held-low line from retriggering a frame.
- Read_ack while Byte_ready=1: clear Byte_ready and Overrun next edge.
- Read_ack while Byte_ready=0: ignored.
- Read_ack coinciding with a good-stop load: the load wins (Byte_ready stays 1) and Overrun is not set.
- Latency: Byte_ready rises on the edge at the stop-bit midpoint, i.e. 9.5*CLKS_PER_BIT + SYNC_STAGES cycles after the falling start edge on Serial_in (±1 cycle).
- Counter widths are $clog2(CLKS_PER_BIT) and $clog2(WORD_SIZE+1). No wrap-around is possible because counters are cleared at terminal count.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, sampled at mid-bit. Adds input Parity_odd (1=odd, 0=even) and output Parity_error.
  - Parity_error is a one-cycle pulse asserted on the STOP-sample edge if the parity check failed.
  - A parity error still loads the byte and sets Byte_ready, unless a framing error also occurs; a framing error suppresses the load as normal.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no Parity_odd/Parity_error ports; the frame is 8N1.

Decomposition:
- Shared package/include uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP, BREAK), default WORD_SIZE and CLKS_PER_BIT, and an idle-level constant. The same package is shared with uart_tx.
- One sub-module, uart_sync: a SYNC_STAGES-deep flop chain with synchronous reset to 1, instantiated once on Serial_in.

Test Plan:
- Send 0x41 at CLKS_PER_BIT=16 (line bits 0,1,0,0,0,0,0,1,0,1) -> uart_rx_data_Bus=8'h41 and Byte_ready=1, ~154 cycles after the start edge; Framing_error never pulses.
- Send 0x55 then 0xAA back-to-back with Read_ack pulsed between them -> bus reads 0x55 then 0xAA; Overrun stays 0.
- Send 0x3C and 0xC3 with no Read_ack -> bus=0xC3, Byte_ready=1, Overrun=1. Then Read_ack -> Byte_ready=0, Overrun=0.
- Drive Serial_in low for 5 cycles only -> return to IDLE; Byte_ready=0; no error; Rx_busy drops within CLKS_PER_BIT/2+SYNC_STAGES+1 cycles.
- Frame 0x7E with the stop bit forced to 0 and the line held low for 40 more cycles -> one Framing_error pulse; bus keeps its previous value; no new frame until the line returns high. A following good 0x12 is received correctly.
- Assert reset during data bit 3 of 0xF0 -> all outputs return to reset values next edge. A following frame 0x0F is received correctly. With UART_RX_PARITY_EN defined and Parity_odd=0, 0x07 sent with parity bit 0 -> Parity_error pulse and bus=0x07.
